// File: rtl/dist_ram_wr_arbiter.sv
// dist_ram_wr_arbiter: round-robin arbiter for the write port of the register-file
// distributed RAM. NUM_REQ requesters use a valid/ready handshake per requester. The
// accepted address/data is registered and drives the RAM write port one cycle later.
// Optional feature: define DIST_RAM_ARB_LOCK_EN to add req_lock. With req_lock set,
// a requester keeps top priority across transfers so it can issue burst writes.
module dist_ram_wr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 5,
    localparam int unsigned ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             freeze,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic                             ram_write_en,
    output logic [ADDRESS_WIDTH-1:0]         ram_in_addr,
    output logic [DATA_WIDTH-1:0]            ram_in,
    output logic [ID_WIDTH-1:0]              last_grant_id
`ifdef DIST_RAM_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]               req_lock
`endif
);

    logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];

    logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;

    logic                     grant_found;
    logic [ID_WIDTH-1:0]      grant_id;
    logic                     xfer;
    int unsigned              cand;
    logic [ID_WIDTH-1:0]      cand_id;

    // Unpack the per-requester address and data buses.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan: first valid requester starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        cand_id     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand    = (32'(ptr_q) + k) % NUM_REQ;
            cand_id = ID_WIDTH'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // Handshake: at most one one-hot ready, suppressed by reset and freeze.
    always_comb begin
        xfer      = grant_found && !freeze && !reset;
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state for the write-port registers and the round-robin pointer.
    always_comb begin
        wen_d  = xfer;
        addr_d = addr_q;
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            addr_d = addr_arr[grant_id];
            data_d = data_arr[grant_id];
            id_d   = grant_id;
            if (grant_id == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + ID_WIDTH'(1);
            end
`ifdef DIST_RAM_ARB_LOCK_EN
            // Parking ptr on a locked winner keeps it first in the scan. If it later
            // drops valid, the same scan simply moves on to the next requester.
            if (req_lock[grant_id]) begin
                ptr_d = grant_id;
            end
`endif
        end
    end

    // State registers with synchronous reset; reset discards any pending capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            id_q   <= id_d;
        end
    end

    assign ram_write_en  = wen_q;
    assign ram_in_addr   = addr_q;
    assign ram_in        = data_q;
    assign last_grant_id = id_q;

endmodule
